// File: rtl/secure_reg_reader_pkg.sv
// Shared types and default constants for the access-controlled register read port.
package secure_reg_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } rd_state_e;

  localparam logic [2:0]  DEF_PRIV_UID    = 3'h4;
  localparam logic [7:0]  DEF_PUBLIC_MASK = 8'h0F;
  localparam int unsigned DENY_CNT_W      = 8;

endpackage

// File: rtl/secure_reader_audit.sv
// Saturating denied-request counter plus the uid of the latest denial.
module secure_reader_audit
  import secure_reg_reader_pkg::*;
#(
  parameter int unsigned UID_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  deny,
  input  logic [UID_W-1:0]      deny_uid,
  output logic [DENY_CNT_W-1:0] deny_count,
  output logic [UID_W-1:0]      last_deny_uid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_count    <= '0;
      last_deny_uid <= '0;
    end else if (deny) begin
      last_deny_uid <= deny_uid;
      if (deny_count != {DENY_CNT_W{1'b1}}) begin
        deny_count <= deny_count + DENY_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/secure_reg_reader.sv
// Access-controlled read port: grants per request, reads the bank, returns data or error.
// Optional audit outputs are built when SECURE_REG_READER_AUDIT_EN is defined.
module secure_reg_reader
  import secure_reg_reader_pkg::*;
#(
  parameter int unsigned         NUM_REGS    = 8,
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         UID_W       = 3,
  parameter int unsigned         ADDR_W      = 3,
  parameter logic [UID_W-1:0]    PRIV_UID    = UID_W'(DEF_PRIV_UID),
  parameter logic [NUM_REGS-1:0] PUBLIC_MASK = NUM_REGS'(DEF_PUBLIC_MASK)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [UID_W-1:0]  req_uid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
`ifdef SECURE_REG_READER_AUDIT_EN
  ,
  output logic [DENY_CNT_W-1:0] deny_count,
  output logic [UID_W-1:0]      last_deny_uid
`endif
);

  // Mask widened to the full address space so indexing can never go out of bounds.
  localparam int unsigned           ADDR_SPAN = 1 << ADDR_W;
  localparam logic [ADDR_SPAN-1:0]  MASK_EXT  = ADDR_SPAN'(PUBLIC_MASK);

  rd_state_e         state, state_nxt;
  logic              grant_q, grant_nxt;
  logic              in_range, grant;
  logic              rd_en_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0] rsp_data_nxt;

  assign req_ready = (state == ST_IDLE);
  assign in_range  = (32'(req_addr) < NUM_REGS);
  assign grant     = in_range && (MASK_EXT[req_addr] || (req_uid == PRIV_UID));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = grant ? ST_READ : ST_RESP;
      ST_READ: state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_RESP;
      ST_RESP: if (rsp_valid && rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; the grant is decided fresh for every request.
  always_comb begin
    rd_en_nxt     = 1'b0;
    rd_addr_nxt   = '0;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;
    grant_nxt     = grant_q;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          grant_nxt = grant;
          if (grant) begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = req_addr;
          end else begin
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = '0;
          end
        end
      end
      ST_READ: ;
      ST_WAIT: begin
        rsp_valid_nxt = 1'b1;
        rsp_err_nxt   = !grant_q;
        rsp_data_nxt  = grant_q ? reg_rd_data : '0;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          rsp_data_nxt  = '0;
          rsp_err_nxt   = 1'b0;
          grant_nxt     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= 1'b0;
      reg_rd_en   <= 1'b0;
      reg_rd_addr <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      grant_q     <= grant_nxt;
      reg_rd_en   <= rd_en_nxt;
      reg_rd_addr <= rd_addr_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_err     <= rsp_err_nxt;
    end
  end

`ifdef SECURE_REG_READER_AUDIT_EN
  logic deny_evt;
  assign deny_evt = req_valid && req_ready && !grant;

  secure_reader_audit #(.UID_W(UID_W)) u_audit (
    .clk           (clk),
    .rst_n         (rst_n),
    .deny          (deny_evt),
    .deny_uid      (req_uid),
    .deny_count    (deny_count),
    .last_deny_uid (last_deny_uid)
  );
`endif

endmodule
